payload_byte_feeder: RTL and testbench

PAYLOAD_BYTE_FEEDER -- requirements
Module: payload_byte_feeder

---
 rtl/payload_byte_feeder.sv | 154 +++++++++++++++
 tb/tb_payload_byte_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_byte_feeder.sv
// Serialises 64-bit AXI-Stream payload beats into one byte per cycle for the character-class match engines.
// Latency: 9 cycles per beat, then MATCH_WAIT drain cycles before the per-packet result is sampled.
// Backpressure: tready is high only in LOAD; the result is held in REPORT until result_ready is seen.
module payload_byte_feeder #(
    parameter int C_S_AXIS_DATA_WIDTH = 64,
    parameter int NUM_ENGINES         = 32,
    parameter int MATCH_WAIT          = 2
) (
    input  logic                               axi_aclk,
    input  logic                               axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic                               s_axis_tvalid,
    input  logic                               s_axis_tlast,
    output logic                               s_axis_tready,
    output logic [7:0]                         char_byte,
    output logic                               char_en,
    output logic                               char_sod,
    input  logic [NUM_ENGINES-1:0]             match_in,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [NUM_ENGINES-1:0]             result_match,
    output logic                               result_any,
    output logic [15:0]                        result_len
);

    localparam int          STRB_W    = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [3:0]  WAIT_LAST = 4'(MATCH_WAIT - 1);

    typedef enum logic [2:0] {IDLE, SOD, LOAD, SHIFT, DRAIN, REPORT} state_t;

    state_t                         state_q, state_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_W-1:0]              strb_q, strb_d;
    logic                           last_q, last_d;
    logic [2:0]                     lane_q, lane_d, lane_nxt;
    logic [3:0]                     wait_q, wait_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic [7:0]                     byte_q, byte_d;
    logic                           en_q, en_d;
    logic                           sod_q, tready_q, rvalid_q;
    logic [NUM_ENGINES-1:0]         rmatch_q, rmatch_d;
    logic                           rany_q, rany_d;
    logic [15:0]                    rlen_q, rlen_d;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        strb_d   = strb_q;
        last_d   = last_q;
        lane_d   = lane_q;
        lane_nxt = lane_q + 3'd1;
        wait_d   = wait_q;
        byte_d   = byte_q;
        en_d     = 1'b0;
        rmatch_d = rmatch_q;
        rany_d   = rany_q;
        rlen_d   = rlen_q;
        // Counter tracks the bytes presented in the cycle now ending.
        cnt_d    = (en_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) state_d = SOD;
            end
            SOD: begin
                cnt_d   = 16'd0;
                state_d = LOAD;
            end
            LOAD: begin
                if (s_axis_tvalid && tready_q) begin
                    data_d  = s_axis_tdata;
                    strb_d  = s_axis_tstrb;
                    last_d  = s_axis_tlast;
                    lane_d  = 3'd0;
                    en_d    = s_axis_tstrb[0];
                    if (s_axis_tstrb[0]) byte_d = s_axis_tdata[7:0];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (lane_q == 3'd7) begin
                    wait_d  = 4'd0;
                    state_d = last_q ? DRAIN : LOAD;
                end else begin
                    lane_d = lane_nxt;
                    en_d   = strb_q[lane_nxt];
                    if (strb_q[lane_nxt]) byte_d = data_q[{lane_nxt, 3'b000} +: 8];
                end
            end
            DRAIN: begin
                if (wait_q == WAIT_LAST) begin
                    rmatch_d = match_in;
                    rany_d   = |match_in;
                    rlen_d   = cnt_q;
                    state_d  = REPORT;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            REPORT: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            strb_q   <= '0;
            last_q   <= 1'b0;
            lane_q   <= 3'd0;
            wait_q   <= 4'd0;
            cnt_q    <= 16'd0;
            byte_q   <= 8'd0;
            en_q     <= 1'b0;
            sod_q    <= 1'b0;
            tready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rmatch_q <= '0;
            rany_q   <= 1'b0;
            rlen_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            last_q   <= last_d;
            lane_q   <= lane_d;
            wait_q   <= wait_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            en_q     <= en_d;
            sod_q    <= (state_d == SOD);
            tready_q <= (state_d == LOAD);
            rvalid_q <= (state_d == REPORT);
            rmatch_q <= rmatch_d;
            rany_q   <= rany_d;
            rlen_q   <= rlen_d;
        end
    end

    // Engines must be held clear for the whole reset, not just after the first edge.
    assign char_sod      = sod_q | ~axi_aresetn;
    assign char_en       = en_q;
    assign char_byte     = byte_q;
    assign s_axis_tready = tready_q;
    assign result_valid  = rvalid_q;
    assign result_match  = rmatch_q;
    assign result_any    = rany_q;
    assign result_len    = rlen_q;

endmodule

// File: tb/tb_payload_byte_feeder.sv
// Self-checking bench for payload_byte_feeder: packet table plus reset and hold sequences.
module tb_payload_byte_feeder;

    localparam int NE = 32;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic [63:0]   s_axis_tdata = '0;
    logic [7:0]    s_axis_tstrb = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [7:0]    char_byte;
    logic          char_en;
    logic          char_sod;
    logic [NE-1:0] match_in = '0;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [NE-1:0] result_match;
    logic          result_any;
    logic [15:0]   result_len;

    payload_byte_feeder dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .char_byte     (char_byte),
        .char_en       (char_en),
        .char_sod      (char_sod),
        .match_in      (match_in),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_match  (result_match),
        .result_any    (result_any),
        .result_len    (result_len)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        int            nbeats;
        logic [63:0]   d0;
        logic [7:0]    s0;
        logic [63:0]   d1;
        logic [7:0]    s1;
        int            gap;
        int            hold;
        logic [NE-1:0] match;
        logic [15:0]   exp_len;
        logic          exp_any;
    } vec_t;

    vec_t       vecs [5];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    int         en_cnt = 0;
    int         sod_cnt = 0;
    int         hs_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge axi_aclk);
            if (axi_aresetn) begin
                if (char_sod) sod_cnt++;
                if (s_axis_tvalid && s_axis_tready) hs_cnt++;
                if (char_en) begin
                    en_cnt++;
                    check("tready_in_shift", s_axis_tready, 0);
                    check("sod_with_en", char_sod, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL byte_sb: got unexpected byte %0h, expected none", char_byte);
                    end else begin
                        check("byte_sb", char_byte, exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic push_bytes(input logic [63:0] d, input logic [7:0] s);
        for (int i = 0; i < 8; i++)
            if (s[i]) exp_q.push_back(d[8*i +: 8]);
    endtask

    task automatic wait_tready();
        int t;
        t = 0;
        while (!s_axis_tready && t < 200) begin
            @(negedge axi_aclk);
            t++;
        end
        if (!s_axis_tready) check("tready_timeout", 0, 1);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
        @(posedge axi_aclk);
        #1;
        s_axis_tdata  = d;
        s_axis_tstrb  = s;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        push_bytes(d, s);
        @(negedge axi_aclk);
        wait_tready();
        @(posedge axi_aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_pkt(input vec_t v);
        int t;
        en_cnt  = 0;
        sod_cnt = 0;
        hs_cnt  = 0;
        match_in = '0;
        send_beat(v.d0, v.s0, v.nbeats == 1);
        if (v.nbeats == 2) begin
            if (v.gap > 0) begin
                wait_tready();
                repeat (v.gap) begin
                    @(negedge axi_aclk);
                    check("gap_en", char_en, 0);
                    check("gap_tready", s_axis_tready, 1);
                end
            end
            send_beat(v.d1, v.s1, 1'b1);
        end
        match_in = v.match;
        t = 0;
        while (!result_valid && t < 100) begin
            @(negedge axi_aclk);
            t++;
        end
        check("result_valid", result_valid, 1);
        check("result_len", result_len, v.exp_len);
        check("result_match", result_match, v.match);
        check("result_any", result_any, v.exp_any);
        check("en_pulses", en_cnt, v.exp_len);
        check("handshakes", hs_cnt, v.nbeats);
        check("sod_pulses", sod_cnt, 1);
        check("sb_empty", exp_q.size(), 0);
        if (v.hold > 0) begin
            match_in = '0;
            s_axis_tvalid = 1'b1;
            repeat (v.hold) begin
                @(negedge axi_aclk);
                check("hold_valid", result_valid, 1);
                check("hold_len", result_len, v.exp_len);
                check("hold_match", result_match, v.match);
                check("hold_tready", s_axis_tready, 0);
            end
            s_axis_tvalid = 1'b0;
            check("hold_no_sod", sod_cnt, 1);
        end
        result_ready = 1'b1;
        @(posedge axi_aclk);
        #1;
        result_ready = 1'b0;
        match_in = '0;
        @(negedge axi_aclk);
        check("valid_drop", result_valid, 0);
    endtask

    initial begin
        vecs[0] = '{1, 64'h77656976_2E000000, 8'hFF, 64'h0, 8'h00, 0, 0, 32'h0, 16'd8, 1'b0};
        vecs[1] = '{2, 64'h01234567_89ABCDEF, 8'hFF, 64'hFEDCBA98_76543210, 8'h0F, 0, 0, 32'h20, 16'd12, 1'b1};
        vecs[2] = '{2, 64'h11223344_55667788, 8'h00, 64'hA1B2C3D4_E5F60718, 8'hA5, 5, 0, 32'h0, 16'd4, 1'b0};
        vecs[3] = '{1, 64'hDEADBEEF_CAFEF00D, 8'h81, 64'h0, 8'h00, 0, 20, 32'h8000_0000, 16'd2, 1'b1};
        vecs[4] = '{2, 64'h0F1E2D3C_4B5A6978, 8'hFF, 64'h8796A5B4_C3D2E1F0, 8'hFF, 5, 0, 32'h3, 16'd16, 1'b1};

        fork
            monitor();
        join_none

        #12;
        check("rst_sod", char_sod, 1);
        check("rst_en", char_en, 0);
        check("rst_byte", char_byte, 0);
        check("rst_tready", s_axis_tready, 0);
        check("rst_valid", result_valid, 0);
        check("rst_len", result_len, 0);
        check("rst_match", result_match, 0);
        check("rst_any", result_any, 0);
        @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        check("post_rst_sod", char_sod, 0);

        for (int i = 0; i < 5; i++)
            run_pkt(vecs[i]);

        // Reset in the middle of the first beat discards the packet.
        en_cnt  = 0;
        sod_cnt = 0;
        send_beat(64'h0102030405060708, 8'hFF, 1'b1);
        begin
            int t;
            t = 0;
            while (en_cnt < 4 && t < 50) begin
                @(negedge axi_aclk);
                t++;
            end
            check("reset_reach_lane3", en_cnt >= 4, 1);
        end
        axi_aresetn = 1'b0;
        #1;
        check("midrst_sod", char_sod, 1);
        check("midrst_en", char_en, 0);
        check("midrst_tready", s_axis_tready, 0);
        check("midrst_valid", result_valid, 0);
        exp_q.delete();
        repeat (3) @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        repeat (12) begin
            @(negedge axi_aclk);
            check("midrst_no_result", result_valid, 0);
        end
        run_pkt(vecs[3]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
